// File: rtl/int_div.sv
// -----------------------------------------------------------------------------
// int_div: sequential unsigned integer divider (radix-2 restoring).
//
// Divides a 2*DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor, producing
// one quotient bit per enabled cycle. Exceptional operands (zero divisor, or a
// quotient that cannot fit in DATA_WIDTH bits) bypass the iteration.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           enable; when low every register holds
//   start        operation request, honoured only in IDLE
//   dividend     2*DATA_WIDTH-bit numerator, captured with start
//   divisor      DATA_WIDTH-bit denominator, captured with start
//   quotient     result quotient (held until next accepted start)
//   remainder    result remainder (held until next accepted start)
//   busy         operation in progress
//   done         one enabled-cycle pulse marking valid results
//   div_by_zero  last operation had a zero divisor
//   overflow     last operation's quotient did not fit in DATA_WIDTH bits
// -----------------------------------------------------------------------------
module int_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic [DATA_WIDTH-1:0]     quotient,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0] divisor_reg;
    logic [DATA_WIDTH-1:0] p_reg;          // partial remainder, always < divisor
    logic [DATA_WIDTH-1:0] q_reg;          // dividend low half shifting out, quotient shifting in
    logic                  dz_pend_reg;    // exception kind captured at accept,
    logic                  ov_pend_reg;    // published together with done
    logic [DATA_WIDTH-1:0] quotient_reg;
    logic [DATA_WIDTH-1:0] remainder_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  div_by_zero_reg;
    logic                  overflow_reg;

    // Operand halves and exception detection at accept time.
    logic [DATA_WIDTH-1:0] div_hi;
    logic [DATA_WIDTH-1:0] div_lo;
    logic                  is_dz;
    logic                  is_ov;

    assign div_hi = dividend[2*DATA_WIDTH-1:DATA_WIDTH];
    assign div_lo = dividend[DATA_WIDTH-1:0];
    assign is_dz  = (divisor == '0);
    assign is_ov  = !is_dz && (div_hi >= divisor);

    // One restoring step. T is W+1 bits wide; when T >= divisor the
    // difference is below divisor, so only its low W bits are needed.
    logic [DATA_WIDTH:0]   t_val;
    logic                  t_ge;
    logic [DATA_WIDTH-1:0] p_sub;

    assign t_val = {p_reg, q_reg[DATA_WIDTH-1]};
    assign t_ge  = (t_val >= {1'b0, divisor_reg});
    assign p_sub = t_val[DATA_WIDTH-1:0] - divisor_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            divisor_reg     <= '0;
            p_reg           <= '0;
            q_reg           <= '0;
            dz_pend_reg     <= 1'b0;
            ov_pend_reg     <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (en) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        divisor_reg     <= divisor;
                        p_reg           <= div_hi;
                        q_reg           <= div_lo;
                        cnt_reg         <= '0;
                        dz_pend_reg     <= is_dz;
                        ov_pend_reg     <= is_ov;
                        div_by_zero_reg <= 1'b0;
                        overflow_reg    <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= (is_dz || is_ov) ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (t_ge) begin
                        p_reg <= p_sub;
                        q_reg <= {q_reg[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        p_reg <= t_val[DATA_WIDTH-1:0];
                        q_reg <= {q_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(DATA_WIDTH - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First enabled cycle publishes results and raises done;
                    // the second retires the operation.
                    if (!done_reg) begin
                        done_reg        <= 1'b1;
                        div_by_zero_reg <= dz_pend_reg;
                        overflow_reg    <= ov_pend_reg;
                        quotient_reg    <= (dz_pend_reg || ov_pend_reg) ? '1 : q_reg;
                        // Zero divisor returns the untouched dividend low half,
                        // which still sits in q_reg because no step ran.
                        remainder_reg   <= ov_pend_reg ? '0 :
                                           (dz_pend_reg ? q_reg : p_reg);
                    end else begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = div_by_zero_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_int_div.sv
// -----------------------------------------------------------------------------
// tb_int_div: directed self-checking bench for int_div at DATA_WIDTH=8.
// -----------------------------------------------------------------------------
module tb_int_div;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic           overflow;

    int checks   = 0;
    int failures = 0;

    int_div #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One division transaction. Latency is counted in edges after the accept
    // edge until done is first seen high.
    //   poke    : pulse a second start during CALC (must be ignored)
    //   gap_at  : after this edge drop en for 3 edges (0 = never)
    //   hold    : edges with en low while done is high
    task automatic run_op(input string name, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                          input int exp_lat, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_dz, input logic exp_ov,
                          input bit poke, input int gap_at, input int hold);
        int n;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, ".busy_after_accept"}, busy, 1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (poke && n == 2) begin
                start    = 1'b1;
                dividend = 16'h0064;
                divisor  = 8'd9;
            end
            if (poke && n == 3) start = 1'b0;
            if (gap_at != 0 && n == gap_at)     en = 1'b0;
            if (gap_at != 0 && n == gap_at + 3) en = 1'b1;
        end
        chk({name, ".latency"}, n, exp_lat);
        chk({name, ".quotient"}, quotient, exp_q);
        chk({name, ".remainder"}, remainder, exp_r);
        chk({name, ".div_by_zero"}, div_by_zero, exp_dz);
        chk({name, ".overflow"}, overflow, exp_ov);
        chk({name, ".busy_at_done"}, busy, 1);
        if (hold > 0) begin
            en = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            chk({name, ".done_held"}, done, 1);
            chk({name, ".busy_held"}, busy, 1);
            en = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, ".done_low"}, done, 0);
        chk({name, ".busy_low"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, ".stays_idle"}, busy, 0);
        chk({name, ".result_held"}, quotient, exp_q);
        $display("op %s: %0h / %0h -> q=%0h r=%0h dz=%0b ov=%0b lat=%0d",
                 name, dvd, dvs, quotient, remainder, div_by_zero, overflow, n);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div1000_7",   16'h03E8, 8'd7,   9,  8'd142, 8'd6,    1'b0, 1'b0, 1'b0, 0, 0);
        run_op("divFEFF_FF",  16'hFEFF, 8'hFF,  9,  8'hFF,  8'hFE,   1'b0, 1'b0, 1'b0, 0, 0);
        run_op("div_zero",    16'h1234, 8'h00,  1,  8'hFF,  8'h34,   1'b1, 1'b0, 1'b0, 0, 0);
        run_op("overflow",    16'h0800, 8'h08,  1,  8'hFF,  8'h00,   1'b0, 1'b1, 1'b0, 0, 0);
        run_op("ignore_start",16'h03E8, 8'd7,   9,  8'd142, 8'd6,    1'b0, 1'b0, 1'b1, 0, 0);
        run_op("en_gap",      16'h03E8, 8'd7,   12, 8'd142, 8'd6,    1'b0, 1'b0, 1'b0, 3, 2);

        // Asynchronous reset in the middle of CALC, between clock edges.
        @(negedge clk);
        dividend = 16'h03E8;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.quotient", quotient, 0);
        chk("async_rst.remainder", remainder, 0);
        chk("async_rst.busy", busy, 0);
        chk("async_rst.flags", {done, div_by_zero, overflow}, 0);
        $display("op async_rst: busy=%0b q=%0h", busy, quotient);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div100_9",    16'h0064, 8'd9,   9,  8'd11,  8'd1,    1'b0, 1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
